// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: transfer direction, controller state, SCL-stretch phase.
package i2c_pkg;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_state_t;

    typedef enum logic [1:0] {
        STR_NONE,
        STR_WAIT,
        STR_HOLD1,
        STR_HOLD2
    } stretch_t;

endpackage

// File: rtl/i2c_target_fifo.sv
// Synchronous FIFO with count-derived flags; push ignored when full, pop ignored when empty.
module i2c_target_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target: synchronised bus sampling, address match, write/read byte FIFOs, optional SCL stretching.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int I2C_DATA_WIDTH = 8,
    parameter int WR_DEPTH       = 16,
    parameter int RD_DEPTH       = 16,
    parameter int STRETCH_EN     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    input  logic [I2C_ADDR_WIDTH-1:0] own_addr,
    output logic [I2C_DATA_WIDTH-1:0] wr_data,
    output logic                      wr_valid,
    input  logic                      wr_pop,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data,
    input  logic                      rd_push,
    output logic                      rd_full,
    output logic                      op,
    output logic                      busy,
    output logic                      start_det,
    output logic                      stop_det,
    output logic                      err
);

    localparam int AW  = I2C_ADDR_WIDTH;
    localparam int DW  = I2C_DATA_WIDTH;
    localparam int SHW = (AW + 1 > DW) ? AW + 1 : DW;
    localparam int CW  = $clog2(SHW + 1);

    logic [1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic       scl_q, sda_q;
    logic       scl_rise, scl_fall, start_cond, stop_cond;

    i2c_state_t     state, state_n;
    logic [CW-1:0]  bit_cnt, bit_cnt_n;
    logic [SHW-1:0] shreg, shreg_n;
    i2c_op_t        op_r, op_n;
    stretch_t       stretch, stretch_n;
    logic           sda_r, sda_n, scl_r, scl_n;
    logic           ack_seen, ack_seen_n;
    logic           busy_r, start_r, stop_r, err_r, err_n;
    logic           load_req;

    logic          wr_push, wr_full, wr_empty;
    logic [DW-1:0] wr_byte;
    logic          rd_pop, rd_empty;
    logic [DW-1:0] rd_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl_q      = scl_sync[1];
    assign sda_q      = sda_sync[1];
    assign scl_rise   = scl_q && !scl_prev;
    assign scl_fall   = !scl_q && scl_prev;
    assign start_cond = scl_q && scl_prev && sda_prev && !sda_q;
    assign stop_cond  = scl_q && scl_prev && !sda_prev && sda_q;
    assign wr_byte    = {shreg[DW-2:0], sda_q};

    i2c_target_fifo #(.WIDTH(DW), .DEPTH(WR_DEPTH)) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_push),
        .push_data (wr_byte),
        .pop       (wr_pop),
        .pop_data  (wr_data),
        .full      (wr_full),
        .empty     (wr_empty)
    );

    i2c_target_fifo #(.WIDTH(DW), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_push),
        .push_data (rd_data),
        .pop       (rd_pop),
        .pop_data  (rd_head),
        .full      (rd_full),
        .empty     (rd_empty)
    );

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        op_n       = op_r;
        sda_n      = sda_r;
        scl_n      = scl_r;
        stretch_n  = stretch;
        ack_seen_n = ack_seen;
        err_n      = 1'b0;
        wr_push    = 1'b0;
        rd_pop     = 1'b0;
        load_req   = 1'b0;
        if (stop_cond) begin
            state_n   = IDLE;
            sda_n     = 1'b1;
            scl_n     = 1'b1;
            stretch_n = STR_NONE;
        end else if (start_cond) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_n     = 1'b1;
            scl_n     = 1'b1;
            stretch_n = STR_NONE;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_n   = {shreg[SHW-2:0], sda_q};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == CW'(AW)) begin
                        if (shreg[AW-1:0] == own_addr) begin
                            state_n = ADDR_ACK;
                            op_n    = sda_q ? READ : WRITE;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                // sda_r doubles as the phase flag: 1 = waiting for the fall that starts ACK.
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (sda_r) begin
                        sda_n = 1'b0;
                    end else begin
                        sda_n     = 1'b1;
                        bit_cnt_n = '0;
                        if (state == ADDR_ACK && op_r == READ) load_req = 1'b1;
                        else                                   state_n  = WR_DATA;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shreg_n   = {shreg[SHW-2:0], sda_q};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DW - 1)) begin
                        if (!wr_full) begin
                            wr_push = 1'b1;
                            state_n = WR_ACK;
                        end else begin
                            err_n   = 1'b1;
                            state_n = IGNORE;
                        end
                    end
                end
                RD_DATA: begin
                    if (stretch == STR_WAIT) begin
                        if (!rd_empty) begin
                            rd_pop              = 1'b1;
                            shreg_n             = '0;
                            shreg_n[DW-1:0]     = rd_head;
                            sda_n               = rd_head[DW-1];
                            stretch_n           = STR_HOLD1;
                        end
                    end else if (stretch == STR_HOLD1) begin
                        stretch_n = STR_HOLD2;
                    end else if (stretch == STR_HOLD2) begin
                        stretch_n = STR_NONE;
                        scl_n     = 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == CW'(DW - 1)) begin
                            sda_n      = 1'b1;
                            ack_seen_n = 1'b0;
                            state_n    = RD_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                            shreg_n   = shreg << 1;
                            sda_n     = shreg[DW-2];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_q) state_n    = IGNORE;
                        else       ack_seen_n = 1'b1;
                    end else if (scl_fall && ack_seen) begin
                        load_req   = 1'b1;
                        ack_seen_n = 1'b0;
                    end
                end
                default: ;
            endcase
            // Start of a read byte: pop now, or stretch / pad with ones when nothing is queued.
            if (load_req) begin
                state_n   = RD_DATA;
                bit_cnt_n = '0;
                if (!rd_empty) begin
                    rd_pop          = 1'b1;
                    shreg_n         = '0;
                    shreg_n[DW-1:0] = rd_head;
                    sda_n           = rd_head[DW-1];
                end else if (STRETCH_EN != 0) begin
                    scl_n     = 1'b0;
                    sda_n     = 1'b1;
                    stretch_n = STR_WAIT;
                end else begin
                    shreg_n[DW-1:0] = '1;
                    sda_n           = 1'b1;
                    err_n           = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            op_r     <= WRITE;
            sda_r    <= 1'b1;
            scl_r    <= 1'b1;
            stretch  <= STR_NONE;
            ack_seen <= 1'b0;
            busy_r   <= 1'b0;
            start_r  <= 1'b0;
            stop_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            op_r     <= op_n;
            sda_r    <= sda_n;
            scl_r    <= scl_n;
            stretch  <= stretch_n;
            ack_seen <= ack_seen_n;
            start_r  <= start_cond;
            stop_r   <= stop_cond;
            err_r    <= err_n;
            if (start_r)     busy_r <= 1'b1;
            else if (stop_r) busy_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    assign sda_o     = sda_r;
    assign scl_o     = scl_r;
    assign op        = op_r;
    assign busy      = busy_r;
    assign start_det = start_r;
    assign stop_det  = stop_r;
    assign err       = err_r;
    assign wr_valid  = !wr_empty;

endmodule
